// File: rtl/z16_multicycle_core.sv
// Z16 multi-cycle core: FETCH/EXEC/MEM/WB/HALT sequencer with req/ack instruction and data buses.
// Registers are deliberately not reset; only control state and outputs are.
module z16_multicycle_core #(
    parameter int                XLEN     = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_rdata,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_retire,
    output logic              o_illegal,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc
);
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [XLEN-1:0]   rf [16];
    logic [ADDR_W-1:0] pc, npc;
    logic [XLEN-1:0]   result;
    logic              wen;

    logic [3:0]        op, rd, rs1, f;
    logic [XLEN-1:0]   imm, a, b, c, alu, sum_imm;
    logic [ADDR_W-1:0] off, pc_inc, target;
    logic              writes, taken;

    assign op  = ir[3:0];
    assign rd  = ir[7:4];
    assign rs1 = ir[11:8];
    assign f   = ir[15:12];

    assign a = (rs1 == 4'd0) ? '0 : rf[rs1];
    assign b = (f == 4'd0)   ? '0 : rf[f];
    assign c = (rd == 4'd0)  ? '0 : rf[rd];

    assign imm     = {{(XLEN-4){f[3]}}, f};
    assign off     = {{(ADDR_W-5){f[3]}}, f, 1'b0};
    assign sum_imm = a + imm;
    assign pc_inc  = pc + ADDR_W'(2);

    always_comb begin
        alu = '0;
        case (op)
            4'h0:    alu = a + b;
            4'h1:    alu = a - b;
            4'h2:    alu = a & b;
            4'h3:    alu = a | b;
            4'h4:    alu = a ^ b;
            4'h5:    alu = sum_imm;
            4'hA:    alu = XLEN'(pc_inc);
            default: alu = '0;
        endcase
    end

    // Branches compare r[rd] against r[rs1]; JAL target uses r[rs1] before any writeback.
    assign taken  = (op == 4'h8 && c == a) || (op == 4'h9 && c != a);
    assign target = (op == 4'hA) ? ADDR_W'(a) + off : (taken ? pc + off : pc_inc);
    assign writes = (op <= 4'h6) || (op == 4'hA);

    assign o_imem_addr = pc;
    assign o_pc        = pc;

    always_ff @(posedge i_clk) begin
        if (state == WB && wen && rd != 4'd0)
            rf[rd] <= result;
    end

    // imem_req comes up one cycle after entering FETCH from reset, so no request
    // is visible while reset is asserted; after WB it is raised on entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            npc          <= RESET_PC;
            ir           <= '0;
            result       <= '0;
            wen          <= 1'b0;
            o_imem_req   <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_retire     <= 1'b0;
            o_illegal    <= 1'b0;
            o_halted     <= 1'b0;
        end else begin
            o_retire  <= 1'b0;
            o_illegal <= 1'b0;
            case (state)
                FETCH: begin
                    if (!o_imem_req) begin
                        o_imem_req <= 1'b1;
                    end else if (i_imem_ack) begin
                        ir         <= i_imem_rdata;
                        o_imem_req <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    npc    <= target;
                    result <= alu;
                    wen    <= writes;
                    case (op)
                        4'h6, 4'h7: begin
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= (op == 4'h7);
                            o_dmem_addr  <= ADDR_W'(sum_imm);
                            o_dmem_wdata <= c;
                            state        <= MEM;
                        end
                        4'hF: begin
                            o_halted <= 1'b1;
                            state    <= HALT;
                        end
                        default: begin
                            o_retire  <= 1'b1;
                            o_illegal <= (op >= 4'hB && op <= 4'hE);
                            state     <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        if (!o_dmem_we)
                            result <= i_dmem_rdata;
                        o_retire <= 1'b1;
                        state    <= WB;
                    end
                end
                WB: begin
                    pc         <= npc;
                    o_imem_req <= 1'b1;
                    state      <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
